// File: rtl/port_resp_fifo.sv
// rtl/port_resp_fifo.sv - int request responder: adds ADDEND, returns results in order via DEPTH-entry FIFO
module port_resp_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDEND = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   ADD_VAL  = 32'(ADDEND);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   rsp_count_q, rsp_count_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic          push, pop;

    // Handshake qualifiers depend only on registered state, so there is no
    // combinational path from the request side to the response side.
    assign req_ready = (count_q != FULL_CNT);
    assign rsp_valid = (count_q != '0);
    assign rsp_data  = rsp_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign rsp_count = rsp_count_q;

    assign push = req_valid & req_ready;
    assign pop  = rsp_valid & rsp_ready;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rsp_count_d = rsp_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = req_data + ADD_VAL;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            rsp_count_d = rsp_count_q + 32'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_count_q <= rsp_count_d;
            mem_q       <= mem_d;
        end
    end

endmodule
